// File: rtl/filt_pkg.sv
// Shared constants and state encoding for the level transmitter and the
// receiving hysteresis glitch filter.
package filt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1
    } state_t;

    localparam int HOLD_DEF    = 14;
    localparam int FILT_THRESH = 10;
    // A level must outlast the filter threshold plus its sampling slack.
    localparam int HOLD_MIN    = FILT_THRESH + 3;

endpackage

// File: rtl/filt_hold_cnt.sv
// Hold-period counter: counts 0..HOLD-1 while enabled, flags the terminal
// count, and clears synchronously.
module filt_hold_cnt #(
    parameter int HOLD = 14,
    parameter int CW   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CW-1:0] TC_VAL = CW'(HOLD - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] cnt_r;

    // Counter register; clear has priority over enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign tc = (cnt_r == TC_VAL);

endmodule

// File: rtl/filt_tx.sv
// Level transmitter: holds each accepted bit on the line for exactly HOLD
// cycles, with a one-entry pending buffer for gap-free streaming.
module filt_tx
    import filt_pkg::*;
#(
    parameter int HOLD      = HOLD_DEF,
    parameter int CW        = 4,
    parameter bit CHECK_MIN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_bit,
    output logic in_ready,
    output logic o,
    output logic busy,
    output logic done
);

    if ((HOLD < 2) || (HOLD >= (2 ** CW))) begin : g_bad_hold
        $error("filt_tx: HOLD must lie in 2..2**CW-1");
    end
    // Short holds are only legal where the line does not feed the filter.
    if (CHECK_MIN && (HOLD < HOLD_MIN)) begin : g_short_hold
        $error("filt_tx: HOLD below HOLD_MIN cannot pass the receive filter");
    end

    state_t state_r;
    state_t state_s;
    logic   o_r;
    logic   o_s;
    logic   done_r;
    logic   done_s;
    logic   pend_v_r;
    logic   pend_b_r;
    logic   load_s;
    logic   accept_s;
    logic   cnt_clr_s;
    logic   cnt_en_s;
    logic   cnt_tc_s;

    filt_hold_cnt #(
        .HOLD (HOLD),
        .CW   (CW)
    ) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .tc    (cnt_tc_s)
    );

    assign in_ready = !pend_v_r;
    assign accept_s = in_valid && !pend_v_r;

    // Next-state and line-level decode.
    always_comb begin
        state_s   = ST_IDLE;
        o_s       = o_r;
        done_s    = 1'b0;
        load_s    = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pend_v_r) begin
                    load_s    = 1'b1;
                    o_s       = pend_b_r;
                    cnt_clr_s = 1'b1;
                    state_s   = ST_HOLD;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_tc_s) begin
                    done_s    = 1'b1;
                    cnt_clr_s = 1'b1;
                    // A waiting bit starts its hold on the same edge: no gap.
                    if (pend_v_r) begin
                        load_s  = 1'b1;
                        o_s     = pend_b_r;
                        state_s = ST_HOLD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_en_s = 1'b1;
                    state_s  = ST_HOLD;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // State, line level, done pulse and pending buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            o_r      <= 1'b0;
            done_r   <= 1'b0;
            pend_v_r <= 1'b0;
            pend_b_r <= 1'b0;
        end else begin
            state_r <= state_s;
            o_r     <= o_s;
            done_r  <= done_s;
            if (load_s) begin
                pend_v_r <= 1'b0;
            end else if (accept_s) begin
                pend_v_r <= 1'b1;
                pend_b_r <= in_bit;
            end
        end
    end

    assign o    = o_r;
    assign done = done_r;
    assign busy = (state_r == ST_HOLD) || pend_v_r;

endmodule

// File: tb/tb_filt_tx.sv
// Self-checking bench for filt_tx: timestamp-based reference model, a
// loopback hysteresis filter, and a short-hold negative case.
module tb_filt_tx;
    import filt_pkg::*;

    localparam int HOLD = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic in_ready, o, busy, done;
    logic v9 = 1'b0;
    logic b9 = 1'b0;
    logic rdy9, o9, busy9, done9;

    filt_tx #(.HOLD(HOLD), .CW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(in_ready), .o(o), .busy(busy), .done(done)
    );

    filt_tx #(.HOLD(9), .CW(4), .CHECK_MIN(1'b0)) dut9 (
        .clk(clk), .rst_n(rst_n), .in_valid(v9), .in_bit(b9),
        .in_ready(rdy9), .o(o9), .busy(busy9), .done(done9)
    );

    always #5 clk = ~clk;

    // Receive-side hysteresis filters (threshold FILT_THRESH).
    logic filt, filt9;
    int   fc, fc9;
    always @(posedge clk) begin
        if (!rst_n) begin
            filt <= 1'b0; fc <= 0; filt9 <= 1'b0; fc9 <= 0;
        end else begin
            if (o != filt) begin
                if (fc == FILT_THRESH - 1) begin filt <= o; fc <= 0; end
                else fc <= fc + 1;
            end else fc <= 0;
            if (o9 != filt9) begin
                if (fc9 == FILT_THRESH - 1) begin filt9 <= o9; fc9 <= 0; end
                else fc9 <= fc9 + 1;
            end else fc9 <= 0;
        end
    end

    int hi9, d9_cnt;
    logic f9_seen;
    always @(posedge clk) begin
        if (!rst_n) begin
            hi9 <= 0; d9_cnt <= 0; f9_seen <= 1'b0;
        end else begin
            if (o9) hi9 <= hi9 + 1;
            if (done9) d9_cnt <= d9_cnt + 1;
            if (filt9) f9_seen <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: line level, edge at which current hold ends, pending bits.
    logic m_o = 1'b0;
    logic m_done = 1'b0;
    int   m_end = -1;
    logic m_pend[$];
    logic last_acc = 1'b0;

    int   ev_t[$];
    logic ev_l[$];
    logic prev_o = 1'b0;
    logic prev_f = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic acc;
        int t;
        logic l;
        @(posedge clk);
        cyc++;
        acc = rst_n && in_valid && (m_pend.size() == 0);
        if (!rst_n) begin
            m_o = 1'b0; m_done = 1'b0; m_end = -1; m_pend.delete();
        end else begin
            m_done = (m_end == cyc);
            if (m_end == cyc) begin
                if (m_pend.size() > 0) begin
                    m_o = m_pend.pop_front(); m_end = cyc + HOLD;
                end else m_end = -1;
            end else if (m_end < 0 && m_pend.size() > 0) begin
                m_o = m_pend.pop_front(); m_end = cyc + HOLD;
            end
            if (acc) m_pend.push_back(in_bit);
        end
        last_acc = acc;
        #1;
        chk("o", {31'd0, o}, {31'd0, m_o});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("busy", {31'd0, busy}, {31'd0, (m_end >= 0) || (m_pend.size() > 0)});
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_pend.size() == 0});
        if (!rst_n) begin
            ev_t.delete(); ev_l.delete();
        end else begin
            if (o !== prev_o) begin ev_t.push_back(cyc); ev_l.push_back(o); end
            if (filt !== prev_f) begin
                if (ev_t.size() == 0) chk("lb_spurious", ev_t.size(), 32'd1);
                else begin
                    t = ev_t.pop_front(); l = ev_l.pop_front();
                    chk("lb_level", {31'd0, filt}, {31'd0, l});
                    chk("lb_delay_le12", {31'd0, (cyc - t) <= 12}, 32'd1);
                end
            end
        end
        prev_o = o;
        prev_f = filt;
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n);
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        in_valid = 1'b1;
        in_bit = bits[0];
        while (idx < n && guard < 40 * n) begin
            step();
            guard++;
            if (last_acc) begin
                idx++;
                if (idx < n) in_bit = bits[idx];
            end
        end
        in_valid = 1'b0;
        chk("send_accepted", idx, n);
    endtask

    initial begin
        // Reset
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single request of 1, then idle past the done pulse
        send_bits(8'b1, 1);
        repeat (20) step();

        // Back-to-back stream 1,0,1,0 with in_valid held
        send_bits(8'b0101, 4);
        repeat (70) step();

        // Same-level requests (line at 0: request 0; then 1, then 1 again)
        send_bits(8'b0, 1);
        repeat (18) step();
        send_bits(8'b1, 1);
        repeat (18) step();
        send_bits(8'b1, 1);
        repeat (18) step();

        // Reset mid-hold with a pending bit
        send_bits(8'b0, 1);
        repeat (18) step();
        in_valid = 1'b1; in_bit = 1'b1; step();
        in_valid = 1'b0; step();
        in_valid = 1'b1; in_bit = 1'b0; step();
        in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0; step();
        rst_n = 1'b1; step();
        send_bits(8'b1, 1);
        repeat (20) step();

        // Random streams, checked cycle by cycle and through loopback
        for (int k = 0; k < 600; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_bit = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(10, 40)) step();
            end else step();
        end
        in_valid = 1'b0;
        repeat (60) step();
        chk("lb_drained", ev_t.size(), 32'd0);

        // Negative: HOLD=9 single-bit pulse must not get through the filter
        v9 = 1'b1; b9 = 1'b1; step();
        b9 = 1'b0;
        for (int k = 0; k < 40 && !rdy9; k++) step();
        step();
        v9 = 1'b0;
        repeat (40) step();
        chk("neg_o9_high_cycles", hi9, 32'd9);
        chk("neg_done9_pulses", d9_cnt, 32'd2);
        chk("neg_filter_blocked", {31'd0, f9_seen}, 32'd0);
        chk("neg_busy9_idle", {31'd0, busy9}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
